// File: rtl/div_unit_pkg.sv
// Shared types and handshake encodings for the multi-cycle restoring divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_START       = 1'b1;
  localparam logic DIV_STOP        = 1'b0;
  localparam logic DIV_RES_READY   = 1'b1;
  localparam logic DIV_RES_NOREADY = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider handshake: EX (master) drives operands/start/annul, divider (slave) returns result/ready.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  import div_unit_pkg::*;

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration on the {rem, quo} partial register.
module div_unit_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] i_part,
  input  logic [DATA_W-1:0]   i_divisor,
  output logic [2*DATA_W-1:0] o_part
);

  logic [DATA_W:0]   w_shrem;
  logic [DATA_W:0]   w_diff;
  logic              w_take;

  // The shifted remainder needs DATA_W+1 bits; when its top bit is set it already exceeds the divisor.
  assign w_shrem = i_part[2*DATA_W-1:DATA_W-1];
  assign w_diff  = {1'b0, w_shrem[DATA_W-1:0]} - {1'b0, i_divisor};
  assign w_take  = w_shrem[DATA_W] | ~w_diff[DATA_W];

  assign o_part = w_take ? {w_diff[DATA_W-1:0], i_part[DATA_W-2:0], 1'b1}
                         : {w_shrem[DATA_W-1:0], i_part[DATA_W-2:0], 1'b0};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32/32 signed/unsigned divider for DIV/DIVU; returns {remainder, quotient}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       Rst_n,
  div_unit_if.slave  bus
);

  div_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [2*DATA_W-1:0]   r_result, w_result_nxt;
  logic                  r_ready, w_ready_nxt;

  logic [2*DATA_W-1:0]   r_part, w_part_nxt;
  logic [DATA_W-1:0]     r_divisor, w_divisor_nxt;
  logic                  r_signed, w_signed_nxt;
  logic                  r_sign1, w_sign1_nxt;
  logic                  r_sign2, w_sign2_nxt;

  logic [2*DATA_W-1:0]   w_step;
  logic                  w_neg1, w_neg2;
  logic [DATA_W-1:0]     w_abs1, w_abs2;
  logic [DATA_W-1:0]     w_quo_fix, w_rem_fix;

  function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] x);
    return ~x + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  div_unit_step #(.DATA_W(DATA_W)) u_step (
    .i_part    (r_part),
    .i_divisor (r_divisor),
    .o_part    (w_step)
  );

  assign w_neg1 = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign w_neg2 = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign w_abs1 = w_neg1 ? neg(bus.opdata1_i) : bus.opdata1_i;
  assign w_abs2 = w_neg2 ? neg(bus.opdata2_i) : bus.opdata2_i;

  assign w_quo_fix = (r_signed & (r_sign1 ^ r_sign2)) ? neg(r_part[DATA_W-1:0])
                                                       : r_part[DATA_W-1:0];
  assign w_rem_fix = (r_signed & r_sign1) ? neg(r_part[2*DATA_W-1:DATA_W])
                                          : r_part[2*DATA_W-1:DATA_W];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;
    w_part_nxt    = r_part;
    w_divisor_nxt = r_divisor;
    w_signed_nxt  = r_signed;
    w_sign1_nxt   = r_sign1;
    w_sign2_nxt   = r_sign2;
    case (r_state)
      DIV_FREE: begin
        w_result_nxt = '0;
        w_ready_nxt  = DIV_RES_NOREADY;
        if (bus.start_i == DIV_START && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            w_state_nxt = DIV_BYZERO;
          end else begin
            w_state_nxt   = DIV_ON;
            w_cnt_nxt     = '0;
            w_part_nxt    = {{DATA_W{1'b0}}, w_abs1};
            w_divisor_nxt = w_abs2;
            w_signed_nxt  = bus.signed_div_i;
            w_sign1_nxt   = w_neg1;
            w_sign2_nxt   = w_neg2;
          end
        end
      end
      DIV_BYZERO: begin
        w_result_nxt = '0;
        if (bus.annul_i) begin
          w_state_nxt = DIV_FREE;
          w_ready_nxt = DIV_RES_NOREADY;
        end else begin
          w_state_nxt = DIV_END;
          w_ready_nxt = DIV_RES_READY;
        end
      end
      DIV_ON: begin
        if (bus.annul_i || bus.start_i == DIV_STOP) begin
          w_state_nxt  = DIV_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = DIV_RES_NOREADY;
        end else if (r_cnt == CNT_W'(DATA_W)) begin
          w_state_nxt  = DIV_END;
          w_result_nxt = {w_rem_fix, w_quo_fix};
          w_ready_nxt  = DIV_RES_READY;
        end else begin
          w_part_nxt = w_step;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
        end
      end
      DIV_END: begin
        if (bus.annul_i || bus.start_i == DIV_STOP) begin
          w_state_nxt  = DIV_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = DIV_RES_NOREADY;
        end
      end
      default: begin
        w_state_nxt  = DIV_FREE;
        w_result_nxt = '0;
        w_ready_nxt  = DIV_RES_NOREADY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      r_state  <= DIV_FREE;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= DIV_RES_NOREADY;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  // Datapath registers carry no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    r_part    <= w_part_nxt;
    r_divisor <= w_divisor_nxt;
    r_signed  <= w_signed_nxt;
    r_sign1   <= w_sign1_nxt;
    r_sign2   <= w_sign2_nxt;
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, abort/reset sequences and randomized ops vs. an arithmetic model.
module tb_div_unit;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int hold_end);
    int   n;
    logic rdy;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = ~sgn;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      rdy = bus.ready_o;
    end
    check({nm, " latency"}, 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
    check({nm, " result"}, bus.result_o, exp);
    for (int i = 0; i < hold_end; i++) begin
      @(posedge clk);
      #1;
      check({nm, " end hold"}, {bus.ready_o, bus.result_o[62:0]}, {1'b1, exp[62:0]});
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check({nm, " drop ready"}, {63'd0, bus.ready_o}, 64'd0);
    check({nm, " drop result"}, bus.result_o, 64'd0);
  endtask

  task automatic abort_op(input string nm, input logic use_annul);
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    if (use_annul) bus.annul_i = 1'b1;
    else           bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check({nm, " ready after abort"}, {63'd0, bus.ready_o}, 64'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    run_op({nm, " restart"}, 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 0);
  endtask

  vec_t vecs[$];

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    int          n;

    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;

    vecs.push_back('{"divu 100/7",        1'b0, 32'd100,      32'd7,        64'h00000002_0000000E});
    vecs.push_back('{"div -7/2",          1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD});
    vecs.push_back('{"div 7/-2",          1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD});
    vecs.push_back('{"div -100/-7",       1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E});
    vecs.push_back('{"div minint/-1",     1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000});
    vecs.push_back('{"divu 8000/ffff",    1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000});
    vecs.push_back('{"divu big divisor",  1'b0, 32'hFFFFFFFF, 32'h80000001, 64'h7FFFFFFE_00000001});
    vecs.push_back('{"div by zero",       1'b1, 32'h12345678, 32'd0,        64'd0});
    vecs.push_back('{"divu by zero",      1'b0, 32'hFFFFFFFF, 32'd0,        64'd0});

    repeat (2) @(posedge clk);
    #1;
    check("reset ready", {63'd0, bus.ready_o}, 64'd0);
    check("reset result", bus.result_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, i % 3);

    // annul and start together in FREE must not launch an operation
    @(negedge clk);
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("annul+start in free", {63'd0, bus.ready_o}, 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;

    abort_op("annul", 1'b1);
    abort_op("stop", 1'b0);

    // reset in mid-operation, then a fresh op
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd999;
    bus.opdata2_i    = 32'd10;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("mid reset ready", {63'd0, bus.ready_o}, 64'd0);
    check("mid reset result", bus.result_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after reset", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 0);

    // reset while END holds a nonzero result
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    n = 0;
    while (!bus.ready_o && n < 45) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pre-reset end result", bus.result_o, 64'h00000002_0000000E);
    @(negedge clk);
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("end reset result", bus.result_o, 64'd0);
    check("end reset ready", {63'd0, bus.ready_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 25; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 5) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = 32'($urandom);
      endcase
      run_op($sformatf("rand%0d %h/%h s%0d", k, a, b, sgn), sgn, a, b, ref_div(sgn, a, b),
             $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
